// File: rtl/voq_in_ctrl.sv
// Input-side VOQ writer: sorts cells by in_dest into PORT_NUB FIFOs, pops the scheduler-selected head.
// Latency: write visible to read the next cycle; rd_data/rd_valid registered, one cycle after rd_in.
// Backpressure: in_ready=!full of in_dest; with VOQ_DROP_EN in_ready=1 and full-VOQ cells are dropped and counted.
module voq_in_ctrl #(
  parameter int PORT_NUB   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int WIDTH_SEL = $clog2(PORT_NUB),
  localparam int CNT_W     = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH_SEL-1:0]  in_dest,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rd_in,
  input  logic [WIDTH_SEL-1:0]  rd_sel_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [PORT_NUB-1:0]   empty_out,
  output logic [PORT_NUB-1:0]   full_out,
  output logic [15:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [CNT_W-1:0]      cnt    [PORT_NUB];
  logic [PTR_W-1:0]      wr_ptr [PORT_NUB];
  logic [PTR_W-1:0]      rd_ptr [PORT_NUB];
  logic [DATA_WIDTH-1:0] mem    [PORT_NUB][DEPTH];

  logic                dest_full;
  logic                wr;
  logic                rd;
  logic [PORT_NUB-1:0] wr_hit;
  logic [PORT_NUB-1:0] rd_hit;

  // Flags come only from registered counts, so no input reaches them combinationally.
  always_comb begin
    empty_out = '0;
    full_out  = '0;
    for (int d = 0; d < PORT_NUB; d++) begin
      empty_out[d] = (cnt[d] == '0);
      full_out[d]  = (cnt[d] == FULL_CNT);
    end
  end

  assign dest_full = full_out[in_dest];
  assign wr        = in_valid & ~dest_full;
  assign rd        = rd_in & ~empty_out[rd_sel_in];

  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    if (wr) wr_hit[in_dest]   = 1'b1;
    if (rd) rd_hit[rd_sel_in] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < PORT_NUB; d++) begin
        cnt[d]    <= '0;
        wr_ptr[d] <= '0;
        rd_ptr[d] <= '0;
      end
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      for (int d = 0; d < PORT_NUB; d++) begin
        if (wr_hit[d]) wr_ptr[d] <= wr_ptr[d] + 1'b1;
        if (rd_hit[d]) rd_ptr[d] <= rd_ptr[d] + 1'b1;
        if (wr_hit[d] && !rd_hit[d])
          cnt[d] <= cnt[d] + 1'b1;
        else if (rd_hit[d] && !wr_hit[d])
          cnt[d] <= cnt[d] - 1'b1;
      end
      rd_valid <= rd;
      if (rd) rd_data <= mem[rd_sel_in][rd_ptr[rd_sel_in]];
    end
  end

  // Cell storage needs no reset: only pointers and counts define what is queued.
  always_ff @(posedge clk) begin
    if (wr) mem[in_dest][wr_ptr[in_dest]] <= in_data;
  end

`ifdef VOQ_DROP_EN
  assign in_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= 16'h0000;
    else if (in_valid && dest_full && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign in_ready = ~dest_full;
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_voq_in_ctrl.sv
// Bench for voq_in_ctrl (PORT_NUB=4, DEPTH=8, DATA_WIDTH=32); define VOQ_DROP_EN to exercise the drop build.
module tb_voq_in_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest;
  logic [31:0] in_data;
  logic        rd_in;
  logic [1:0]  rd_sel_in;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  empty_out;
  logic [3:0]  full_out;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: one queue per VOQ plus a queue of cells expected on rd_data.
  logic [31:0] vq [4][$];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  logic [15:0] mdl_drop;

  voq_in_ctrl #(.PORT_NUB(4), .DATA_WIDTH(32), .DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .rd_in(rd_in), .rd_sel_in(rd_sel_in), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty_out(empty_out), .full_out(full_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_ready(input logic [1:0] dest);
`ifdef VOQ_DROP_EN
    return 1'b1;
`else
    return (vq[dest].size() < 8);
`endif
  endfunction

  // One clock: checks in_ready before the edge, advances the model, then checks all outputs after it.
  task automatic tick();
    logic do_wr, do_rd, do_drop, er;
    logic [31:0] ed;
    logic [3:0] ee, ef;
    #1;
    er = exp_ready(in_dest);
    if (!rst) begin
      tests++;
      if (in_ready !== er) begin
        fails++;
        $display("FAIL in_ready dest=%0d got=%b want=%b", in_dest, in_ready, er);
      end
    end
    do_rd   = rd_in && (vq[rd_sel_in].size() > 0);
    do_wr   = in_valid && (vq[in_dest].size() < 8);
`ifdef VOQ_DROP_EN
    do_drop = in_valid && (vq[in_dest].size() == 8);
`else
    do_drop = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) vq[i].delete();
      exp_q.delete();
      last_rd  = 32'h0;
      mdl_drop = 16'h0;
      do_rd    = 1'b0;
    end else begin
      if (do_rd) exp_q.push_back(vq[rd_sel_in].pop_front());
      if (do_wr) vq[in_dest].push_back(in_data);
      if (do_drop && mdl_drop != 16'hFFFF) mdl_drop++;
    end
    tests++;
    if (rd_valid !== do_rd) begin
      fails++;
      $display("FAIL rd_valid got=%b want=%b", rd_valid, do_rd);
    end
    ed = last_rd;
    if (do_rd) begin
      ed = exp_q.pop_front();
      last_rd = ed;
    end
    tests++;
    if (rd_data !== ed) begin
      fails++;
      $display("FAIL rd_data got=%h want=%h", rd_data, ed);
    end
    for (int i = 0; i < 4; i++) begin
      ee[i] = (vq[i].size() == 0);
      ef[i] = (vq[i].size() == 8);
    end
    tests++;
    if (empty_out !== ee || full_out !== ef) begin
      fails++;
      $display("FAIL flags empty got=%h want=%h full got=%h want=%h", empty_out, ee, full_out, ef);
    end
    tests++;
    if (drop_cnt !== mdl_drop) begin
      fails++;
      $display("FAIL drop_cnt got=%0d want=%0d", drop_cnt, mdl_drop);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    rd_in    = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] dest, input logic [31:0] data);
    in_valid = 1'b1; in_dest = dest; in_data = data; rd_in = 1'b0;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [1:0] sel);
    in_valid = 1'b0; rd_in = 1'b1; rd_sel_in = sel;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    in_dest = 2'd0; in_data = 32'h0; rd_sel_in = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (empty_out !== 4'hF || full_out !== 4'h0 || rd_valid !== 1'b0 || in_ready !== 1'b1 || drop_cnt !== 16'h0) begin
      fails++;
      $display("FAIL reset empty=%h full=%h rd_valid=%b in_ready=%b drop=%0d want F 0 0 1 0",
               empty_out, full_out, rd_valid, in_ready, drop_cnt);
    end
    tick();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) do_write(2'd2, 32'hA0 + i);
    for (int i = 0; i < 3; i++) do_read(2'd2);
    tests++;
    if (empty_out[2] !== 1'b1) begin
      fails++;
      $display("FAIL basic_empty2 got=%b want=1", empty_out[2]);
    end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 8; i++) do_write(2'd1, 32'h100 + i);
    tests++;
    if (full_out !== 4'h2) begin
      fails++;
      $display("FAIL fill_full got=%h want=2", full_out);
    end
    in_dest = 2'd1;
    #1;
    tests++;
    if (in_ready !== exp_ready(2'd1)) begin
      fails++;
      $display("FAIL fill_ready_d1 got=%b want=%b", in_ready, exp_ready(2'd1));
    end
    in_dest = 2'd3;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fill_ready_d3 got=%b want=1", in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      do_read(2'd1);
      do_write(2'd1, 32'h200 + i);
    end
  endtask

  task automatic test_empty_wr_rd();
    in_valid = 1'b1; in_dest = 2'd0; in_data = 32'hB0;
    rd_in = 1'b1; rd_sel_in = 2'd0;
    tick();
    idle();
    tests++;
    if (rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL nobypass rd_valid got=%b want=0", rd_valid);
    end
    do_read(2'd0);
    tests++;
    if (rd_data !== 32'hB0) begin
      fails++;
      $display("FAIL nobypass rd_data got=%h want=000000b0", rd_data);
    end
  endtask

  task automatic test_full_wr_rd();
    in_valid = 1'b1; in_dest = 2'd1; in_data = 32'hC5;
    rd_in = 1'b1; rd_sel_in = 2'd1;
    tick();
    rd_in = 1'b0;
    tests++;
    if (full_out[1] !== 1'b0) begin
      fails++;
      $display("FAIL full_rd_refuse full1 got=%b want=0", full_out[1]);
    end
    tick();
    idle();
    tests++;
    if (full_out[1] !== 1'b1) begin
      fails++;
      $display("FAIL full_retry full1 got=%b want=1", full_out[1]);
    end
    for (int i = 0; i < 8; i++) do_read(2'd1);
    tests++;
    if (rd_data !== 32'hC5) begin
      fails++;
      $display("FAIL full_retry_tail got=%h want=000000c5", rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic held;
    held = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_dest  = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      rd_in     = ($urandom_range(0, 2) != 0);
      rd_sel_in = 2'($urandom_range(0, 3));
      held = in_valid && !exp_ready(in_dest);
      tick();
    end
    idle();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 8; i++) do_read(2'(d));
  endtask

`ifdef VOQ_DROP_EN
  task automatic test_drop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) do_write(2'd3, 32'h300 + i);
    for (int i = 0; i < 3; i++) do_write(2'd3, 32'hDEAD0 + i);
    tests++;
    if (drop_cnt !== 16'd3) begin
      fails++;
      $display("FAIL drop_count got=%0d want=3", drop_cnt);
    end
    for (int i = 0; i < 8; i++) do_read(2'd3);
    tests++;
    if (rd_data !== 32'h307 || empty_out[3] !== 1'b1) begin
      fails++;
      $display("FAIL drop_contents last=%h empty3=%b want 00000307 1", rd_data, empty_out[3]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_fill_wrap();
    test_empty_wr_rd();
    test_full_wr_rd();
    test_back_to_back();
`ifdef VOQ_DROP_EN
    test_drop();
`endif
    rst = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
